// File: rtl/mod_addsub_pipe_pkg.sv
// Shared definitions for the pipelined modular add/subtract unit:
// operation encodings and default datapath geometry.
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 12
`endif

package mod_addsub_pipe_pkg;

  localparam int DEFAULT_WIDTH = `DATA_SIZE_ARB;
  localparam int DEFAULT_LANES = 2;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'd0,
    MODE_SUB  = 2'd1,
    MODE_NEG  = 2'd2,
    MODE_BFLY = 2'd3
  } mode_e;

  // NEG is the only operation that ignores the b operand.
  function automatic logic mode_uses_b(input mode_e m);
    return m != MODE_NEG;
  endfunction

endpackage

// File: rtl/mod_addsub_pipe_if.sv
// Valid/ready bus for mod_addsub_pipe: operand side in, result side out.
// The slave modport is the unit's view, the master modport the producer/consumer's.
interface mod_addsub_pipe_if
  import mod_addsub_pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int LANES = DEFAULT_LANES
);

  logic [WIDTH-1:0]       q;
  mode_e                  mode;
  logic [LANES*WIDTH-1:0] a;
  logic [LANES*WIDTH-1:0] b;
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] res0;
  logic [LANES*WIDTH-1:0] res1;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES-1:0]       out_err;

  modport master (
    output q, mode, a, b, in_valid, out_ready,
    input  in_ready, res0, res1, out_valid, out_err
  );

  modport slave (
    input  q, mode, a, b, in_valid, out_ready,
    output in_ready, res0, res1, out_valid, out_err
  );

endinterface

// File: rtl/mod_addsub_lane.sv
// One lane of the modular add/sub datapath: stage 1 forms raw W+1-bit sums,
// differences and negations; stage 2 applies a single modular correction.
module mod_addsub_lane
  import mod_addsub_pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s1_en_i,
  input  logic             s2_en_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] q_i,
  input  mode_e            mode_i,
  input  logic [WIDTH-1:0] q_s1_i,
  input  mode_e            mode_s1_i,
  output logic [WIDTH-1:0] res0_o,
  output logic [WIDTH-1:0] res1_o,
  output logic             err_o
);

  logic [WIDTH:0]   sum_d, sum_q;
  logic [WIDTH:0]   diff_d, diff_q;
  logic [WIDTH-1:0] neg_d, neg_q;
  logic             err_d, err_q;

  logic [WIDTH:0]   sum_red;
  logic [WIDTH-1:0] sum_corr, diff_corr;
  logic [WIDTH-1:0] res0_d, res0_q, res1_d, res1_q;
  logic             err_out_q;

  // Top bit of diff is the borrow of a - b.
  assign sum_d  = {1'b0, a_i} + {1'b0, b_i};
  assign diff_d = {1'b0, a_i} - {1'b0, b_i};
  assign neg_d  = (a_i == '0) ? '0 : q_i - a_i;
  assign err_d  = (a_i >= q_i) || (mode_uses_b(mode_i) && (b_i >= q_i));

  assign sum_red   = sum_q - {1'b0, q_s1_i};
  assign sum_corr  = (sum_q >= {1'b0, q_s1_i}) ? sum_red[WIDTH-1:0] : sum_q[WIDTH-1:0];
  assign diff_corr = diff_q[WIDTH] ? diff_q[WIDTH-1:0] + q_s1_i : diff_q[WIDTH-1:0];

  always_comb begin
    res0_d = sum_corr;
    res1_d = '0;
    case (mode_s1_i)
      MODE_ADD:  res0_d = sum_corr;
      MODE_SUB:  res0_d = diff_corr;
      MODE_NEG:  res0_d = neg_q;
      MODE_BFLY: begin
        res0_d = sum_corr;
        res1_d = diff_corr;
      end
      default:   res0_d = sum_corr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q     <= '0;
      diff_q    <= '0;
      neg_q     <= '0;
      err_q     <= 1'b0;
      res0_q    <= '0;
      res1_q    <= '0;
      err_out_q <= 1'b0;
    end else begin
      if (s1_en_i) begin
        sum_q  <= sum_d;
        diff_q <= diff_d;
        neg_q  <= neg_d;
        err_q  <= err_d;
      end
      if (s2_en_i) begin
        res0_q    <= res0_d;
        res1_q    <= res1_d;
        err_out_q <= err_q;
      end
    end
  end

  assign res0_o = res0_q;
  assign res1_o = res1_q;
  assign err_o  = err_out_q;

endmodule

// File: rtl/mod_addsub_pipe.sv
// Multi-lane, two-stage pipelined modular add/sub/neg/butterfly unit with
// full valid/ready back-pressure; q and mode travel with each transaction.
module mod_addsub_pipe
  import mod_addsub_pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int LANES = DEFAULT_LANES
) (
  input logic               clk,
  input logic               reset,
  mod_addsub_pipe_if.slave  io
);

  logic             s1_valid_d, s1_valid_q;
  logic             s2_valid_d, s2_valid_q;
  logic [WIDTH-1:0] q_s1_q;
  mode_e            mode_s1_q;

  logic s2_adv, s1_adv, accept;

  logic [LANES*WIDTH-1:0] res0_w, res1_w;
  logic [LANES-1:0]       err_w;

  // in_ready depends combinationally on out_ready; there is no skid buffer.
  assign s2_adv      = !s2_valid_q || io.out_ready;
  assign s1_adv      = s1_valid_q && s2_adv;
  assign io.in_ready = !reset && (!s1_valid_q || s2_adv);
  assign accept      = io.in_valid && io.in_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (accept) begin
      s1_valid_d = 1'b1;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      q_s1_q     <= '0;
      mode_s1_q  <= MODE_ADD;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (accept) begin
        q_s1_q    <= io.q;
        mode_s1_q <= io.mode;
      end
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    mod_addsub_lane #(
      .WIDTH (WIDTH)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .s1_en_i   (accept),
      .s2_en_i   (s1_adv),
      .a_i       (io.a[gi*WIDTH +: WIDTH]),
      .b_i       (io.b[gi*WIDTH +: WIDTH]),
      .q_i       (io.q),
      .mode_i    (io.mode),
      .q_s1_i    (q_s1_q),
      .mode_s1_i (mode_s1_q),
      .res0_o    (res0_w[gi*WIDTH +: WIDTH]),
      .res1_o    (res1_w[gi*WIDTH +: WIDTH]),
      .err_o     (err_w[gi])
    );
  end

  assign io.res0      = res0_w;
  assign io.res1      = res1_w;
  assign io.out_err   = err_w;
  assign io.out_valid = s2_valid_q;

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Self-checking bench for mod_addsub_pipe: directed vectors plus randomized
// traffic under varying back-pressure, scored against a modular-arithmetic model.
module tb_mod_addsub_pipe;
  import mod_addsub_pipe_pkg::*;

  localparam int W = 12;
  localparam int L = 2;
  localparam int MASK = (1 << W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mod_addsub_pipe_if #(.WIDTH(W), .LANES(L)) bus ();

  mod_addsub_pipe #(.WIDTH(W), .LANES(L)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  typedef struct {
    logic [L*W-1:0] r0;
    logic [L*W-1:0] r1;
    logic [L-1:0]   err;
    bit             lat_chk;
    int             acc_cyc;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int inflight = 0;
  int or_mode  = 0;
  int or_cnt   = 0;

  bit             cur_use_exp = 0;
  bit             cur_lat     = 0;
  logic [L*W-1:0] cur_x0, cur_x1;
  logic [L-1:0]   cur_xe;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Reference: modular add/sub/neg from the arithmetic rules, single correction.
  function automatic exp_t model(input int m, input int qv, input logic [L*W-1:0] av,
                                 input logic [L*W-1:0] bv);
    exp_t e;
    e.r0 = '0; e.r1 = '0; e.err = '0; e.lat_chk = 0; e.acc_cyc = 0;
    for (int i = 0; i < L; i++) begin
      int a, b, s, d, r0, r1;
      a = int'(av[i*W +: W]);
      b = int'(bv[i*W +: W]);
      s = a + b;
      if (s >= qv) s = s - qv;
      d = a - b;
      if (d < 0) d = d + qv;
      r1 = 0;
      case (m)
        0: r0 = s;
        1: r0 = d;
        2: r0 = (a == 0) ? 0 : qv - a;
        default: begin r0 = s; r1 = d; end
      endcase
      e.r0[i*W +: W] = r0[W-1:0];
      e.r1[i*W +: W] = r1[W-1:0];
      e.err[i] = (a >= qv) || ((m != 2) && (b >= qv));
    end
    return e;
  endfunction

  task automatic send(input int m, input int qv, input logic [L*W-1:0] av,
                      input logic [L*W-1:0] bv, input bit use_exp,
                      input logic [L*W-1:0] x0, input logic [L*W-1:0] x1,
                      input logic [L-1:0] xe, input bit lat);
    bit got;
    bus.mode     = mode_e'(m[1:0]);
    bus.q        = qv[W-1:0];
    bus.a        = av;
    bus.b        = bv;
    bus.in_valid = 1'b1;
    cur_use_exp  = use_exp;
    cur_x0       = x0;
    cur_x1       = x1;
    cur_xe       = xe;
    cur_lat      = lat;
    got = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (bus.in_ready) got = 1;
    end
    if (!got) check_val("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    cur_use_exp  = 0;
    cur_lat      = 0;
  endtask

  task automatic send_rand();
    int m, qv;
    logic [L*W-1:0] av, bv;
    m  = $urandom_range(0, 3);
    qv = $urandom_range(2, MASK);
    for (int i = 0; i < L; i++) begin
      int ra, rb;
      ra = ($urandom_range(0, 7) == 0) ? $urandom_range(0, MASK) : $urandom_range(0, qv - 1);
      rb = ($urandom_range(0, 7) == 0) ? $urandom_range(0, MASK) : $urandom_range(0, qv - 1);
      av[i*W +: W] = ra[W-1:0];
      bv[i*W +: W] = rb[W-1:0];
    end
    send(m, qv, av, bv, 0, '0, '0, '0, 0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (inflight != 0 && k < 500) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (inflight != 0) check_val("drain_timeout", 64'(inflight), 0);
    @(posedge clk);
    #1;
  endtask

  // Downstream ready patterns: 0 always, 1 the 1,0,0 cycle, 2 random, 3 never.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (or_mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = (or_cnt % 3 == 0);
        2: bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
      or_cnt++;
    end
  end

  // Monitor: handshakes, scoreboard, in_ready occupancy rule, stall stability.
  initial begin
    bit rst_prev, hold_prev, acc, drn;
    logic [L*W-1:0] r0_prev, r1_prev;
    logic [L-1:0]   e_prev;
    exp_t e;
    rst_prev = 0;
    hold_prev = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        check_val("in_ready_rst", bus.in_ready, 0);
        if (rst_prev) begin
          check_val("out_valid_rst", bus.out_valid, 0);
          check_val("res0_rst", bus.res0, 0);
          check_val("res1_rst", bus.res1, 0);
          check_val("err_rst", bus.out_err, 0);
        end
        sb.delete();
        inflight = 0;
        hold_prev = 0;
      end else begin
        check_val("in_ready", bus.in_ready, !(inflight == 2 && !bus.out_ready));
        if (hold_prev) begin
          check_val("stall_valid", bus.out_valid, 1);
          check_val("stall_res0", bus.res0, r0_prev);
          check_val("stall_res1", bus.res1, r1_prev);
          check_val("stall_err", bus.out_err, e_prev);
        end
        acc = bus.in_valid && bus.in_ready;
        drn = bus.out_valid && bus.out_ready;
        if (drn) begin
          if (sb.size() == 0) begin
            check_val("spurious_out", 1, 0);
          end else begin
            e = sb.pop_front();
            check_val("res0", bus.res0, e.r0);
            check_val("res1", bus.res1, e.r1);
            check_val("out_err", bus.out_err, e.err);
            if (e.lat_chk) check_val("latency", 64'(cyc - e.acc_cyc), 2);
          end
        end
        if (acc) begin
          e = model(int'(bus.mode), int'(bus.q), bus.a, bus.b);
          if (cur_use_exp) begin
            e.r0 = cur_x0;
            e.r1 = cur_x1;
            e.err = cur_xe;
          end
          e.lat_chk = cur_lat;
          e.acc_cyc = cyc;
          sb.push_back(e);
        end
        inflight = inflight + int'(acc) - int'(drn);
        hold_prev = bus.out_valid && !bus.out_ready;
        r0_prev = bus.res0;
        r1_prev = bus.res1;
        e_prev  = bus.out_err;
      end
      rst_prev = reset;
    end
  end

  initial begin
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.q    = '0;
    bus.mode = MODE_ADD;
    bus.a    = '0;
    bus.b    = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    send(0, 3329, {12'd0, 12'd3000}, {12'd0, 12'd1000}, 1, {12'd0, 12'd671}, '0, 2'b00, 1);
    drain();
    send(1, 3329, {12'd5, 12'd5}, {12'd10, 12'd10}, 1, {12'd3324, 12'd3324}, '0, 2'b00, 0);
    send(3, 3329, {12'd3328, 12'd3328}, {12'd1, 12'd1}, 1, {12'd0, 12'd0},
         {12'd3327, 12'd3327}, 2'b00, 0);
    send(2, 3329, {12'd1, 12'd0}, {12'd3000, 12'd77}, 1, {12'd3328, 12'd0}, '0, 2'b00, 0);
    send(0, 4095, {12'd4094, 12'd4094}, {12'd4094, 12'd4094}, 1, {12'd4093, 12'd4093},
         '0, 2'b00, 0);
    send(1, 4095, {12'd0, 12'd0}, {12'd4094, 12'd4094}, 1, {12'd1, 12'd1}, '0, 2'b00, 0);
    send(0, 3329, {12'd100, 12'd3329}, {12'd200, 12'd0}, 1, {12'd300, 12'd0}, '0, 2'b01, 0);
    drain();

    or_mode = 1;
    or_cnt  = 0;
    for (int i = 0; i < 8; i++) send_rand();
    drain();

    or_mode = 2;
    for (int i = 0; i < 300; i++) send_rand();
    or_mode = 0;
    drain();

    or_mode = 3;
    @(posedge clk);
    #1;
    send_rand();
    send_rand();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    or_mode = 0;
    send(0, 3329, {12'd5, 12'd3328}, {12'd7, 12'd2}, 1, {12'd12, 12'd1}, '0, 2'b00, 1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
